// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
//   arb_state_t  : FSM encoding (IDLE, GRANT)
//   clog2_min1() : index width that never collapses to 0 bits
//   ARB_MAX_N    : largest supported channel count
package arb_pkg;

  localparam int ARB_MAX_N = 32;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_enc_pick.sv
// rr_pick: combinational rotating-priority winner search.
//   req      in  N      request vector
//   ptr      in  IDX_W  highest-priority channel (must be < N)
//   mask_idx in  IDX_W  channel excluded from this pick when mask_en=1
//   mask_en  in  1      enable for mask_idx
//   any      out 1      some unmasked request exists
//   idx      out IDX_W  winning channel index (0 when any=0)
//   onehot   out N      one-hot winner (0 when any=0)
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] mask_idx,
  input  logic             mask_en,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot
);

  logic [N-1:0]   masked;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   window;
  int unsigned    pos;

  // Rotating {req,req} right by ptr puts channel ptr at bit 0, so the
  // lowest set bit of the low half is the first requester in search order.
  always_comb begin
    masked = req;
    if (mask_en) begin
      masked[mask_idx] = 1'b0;
    end
    dbl    = {masked, masked} >> ptr;
    window = dbl[N-1:0];
    any    = 1'b0;
    idx    = '0;
    pos    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (window[k] && !any) begin
        any = 1'b1;
        pos = 32'(ptr) + k;
        if (pos >= N) begin
          pos = pos - N;
        end
        idx = IDX_W'(pos);
      end
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_enc.sv
// rr_arbiter_enc: round-robin arbiter with registered one-hot and binary grant.
// Optional feature macro: RR_ARB_LOCK_EN (adds `lock` burst-lock input).
//   clk        in  1      rising-edge clock
//   rst        in  1      synchronous active-high reset
//   lock       in  1      (RR_ARB_LOCK_EN only) keep current grant on accept
//   req        in  N      request vector
//   gnt_ready  in  1      resource accepts current grant
//   gnt_valid  out 1      grant outputs valid
//   gnt_onehot out N      one-hot grant, 0 when idle
//   gnt_idx    out IDX_W  binary grant index, 0 when idle
module rr_arbiter_enc
  import arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = clog2_min1(N)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  input  logic [N-1:0]     req,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  if (N < 2 || N > ARB_MAX_N) begin : g_bad_n
    $error("rr_arbiter_enc: N out of range");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic             accept;
  logic             hold_lock;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;

  // On an accept the search already starts from the rotated pointer with the
  // accepted channel masked, so the follow-on grant lands in the same edge.
  always_comb begin
    accept   = (state == GRANT) && gnt_ready;
    next_ptr = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    pick_ptr = accept ? next_ptr : ptr;
`ifdef RR_ARB_LOCK_EN
    hold_lock = lock && req[gnt_idx];
`else
    hold_lock = 1'b0;
`endif
  end

  rr_pick #(.N(N)) u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask_idx (gnt_idx),
    .mask_en  (accept),
    .any      (pick_any),
    .idx      (pick_idx),
    .onehot   (pick_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gnt_valid  <= 1'b0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state      <= GRANT;
            gnt_valid  <= 1'b1;
            gnt_onehot <= pick_onehot;
            gnt_idx    <= pick_idx;
          end
        end
        GRANT: begin
          if (gnt_ready && !hold_lock) begin
            ptr <= next_ptr;
            if (pick_any) begin
              gnt_onehot <= pick_onehot;
              gnt_idx    <= pick_idx;
            end else begin
              state      <= IDLE;
              gnt_valid  <= 1'b0;
              gnt_onehot <= '0;
              gnt_idx    <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Self-checking bench for rr_arbiter_enc (N=4 main instance, N=5 wrap instance).
module tb_rr_arbiter_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [3:0] gnt_onehot;
  logic [1:0] gnt_idx;
`ifdef RR_ARB_LOCK_EN
  logic       lock = 1'b0;
`endif

  logic [4:0] req5 = '0;
  logic       gnt_ready5 = 1'b0;
  logic       gnt_valid5;
  logic [4:0] gnt_onehot5;
  logic [2:0] gnt_idx5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter_enc #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RR_ARB_LOCK_EN
    .lock       (lock),
`endif
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  rr_arbiter_enc #(.N(5)) dut5 (
    .clk        (clk),
    .rst        (rst),
`ifdef RR_ARB_LOCK_EN
    .lock       (1'b0),
`endif
    .req        (req5),
    .gnt_ready  (gnt_ready5),
    .gnt_valid  (gnt_valid5),
    .gnt_onehot (gnt_onehot5),
    .gnt_idx    (gnt_idx5)
  );

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    gnt_ready = 1'b0;
    req5 = '0;
    gnt_ready5 = 1'b0;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || gnt_idx !== 2'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got valid=%b onehot=%b idx=%0d, want 0/0000/0",
                 i, gnt_valid, gnt_onehot, gnt_idx);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_fairness();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    logic [3:0] exp_oh;
    do_reset();
    req = 4'b1111;
    gnt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp_oh = 4'b0001 << exp_seq[i];
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'(exp_seq[i]) || gnt_onehot !== exp_oh) begin
        errors++;
        $display("FAIL fairness[%0d]: got valid=%b idx=%0d onehot=%b, want 1/%0d/%b",
                 i, gnt_valid, gnt_idx, gnt_onehot, exp_seq[i], exp_oh);
      end
    end
    gnt_ready = 1'b0;
    req = '0;
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0101;
    gnt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || gnt_onehot !== 4'b0001) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b idx=%0d onehot=%b, want 1/0/0001",
                 i, gnt_valid, gnt_idx, gnt_onehot);
      end
      if (i == 1) req = 4'b0100;
    end
    gnt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd2 || gnt_onehot !== 4'b0100) begin
      errors++;
      $display("FAIL hold_next: got valid=%b idx=%0d onehot=%b, want 1/2/0100",
               gnt_valid, gnt_idx, gnt_onehot);
    end
    gnt_ready = 1'b0;
    req = '0;
  endtask

  task automatic test_wrap();
    int exp5[5] = '{0, 4, 0, 4, 0};
    logic [4:0] exp_oh5;
    do_reset();
    req = 4'b1000;
    gnt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd3 || gnt_onehot !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_hi: got valid=%b idx=%0d onehot=%b, want 1/3/1000",
               gnt_valid, gnt_idx, gnt_onehot);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL wrap_idle: got valid=%b onehot=%b idx=%0d, want 0/0000/0",
               gnt_valid, gnt_onehot, gnt_idx);
    end
    req = 4'b1001;
    gnt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || gnt_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_lo: got valid=%b idx=%0d onehot=%b, want 1/0/0001",
               gnt_valid, gnt_idx, gnt_onehot);
    end
    req = '0;
    req5 = 5'b10001;
    gnt_ready5 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_oh5 = 5'b00001 << exp5[i];
      checks++;
      if (gnt_valid5 !== 1'b1 || gnt_idx5 !== 3'(exp5[i]) || gnt_onehot5 !== exp_oh5) begin
        errors++;
        $display("FAIL wrap_n5[%0d]: got valid=%b idx=%0d onehot=%b, want 1/%0d/%b",
                 i, gnt_valid5, gnt_idx5, gnt_onehot5, exp5[i], exp_oh5);
      end
    end
    req5 = '0;
    gnt_ready5 = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b1111;
    gnt_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    gnt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b idx=%0d, want 1/1", gnt_valid, gnt_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b0 || gnt_onehot !== 4'b0000 || gnt_idx !== 2'd0) begin
      errors++;
      $display("FAIL midrst_drop: got valid=%b onehot=%b idx=%0d, want 0/0000/0",
               gnt_valid, gnt_onehot, gnt_idx);
    end
    rst = 1'b0;
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0 || gnt_onehot !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_after: got valid=%b idx=%0d onehot=%b, want 1/0/0001",
               gnt_valid, gnt_idx, gnt_onehot);
    end
    req = '0;
  endtask

`ifdef RR_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    req = 4'b0011;
    lock = 1'b1;
    gnt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 2'd0) begin
        errors++;
        $display("FAIL lock[%0d]: got valid=%b idx=%0d, want 1/0", i, gnt_valid, gnt_idx);
      end
    end
    lock = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 2'd1) begin
      errors++;
      $display("FAIL lock_release: got valid=%b idx=%0d, want 1/1", gnt_valid, gnt_idx);
    end
    gnt_ready = 1'b0;
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_hold();
    test_wrap();
    test_mid_reset();
`ifdef RR_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
